bip_dmem_arbiter: RTL



---
 rtl/bip_dmem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bip_dmem_arbiter.sv
// Two-port req/gnt arbiter sharing the BIP data memory port
// between the CPU (port 0) and the debug/UART unit (port 1).
module bip_dmem_arbiter #(
    parameter int NB_DATA          = 16,
    parameter int LOG2_N_DATA_ADDR = 10,
    parameter int FIXED_PRIO       = 0
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_req0,
    input  logic                        i_we0,
    input  logic [LOG2_N_DATA_ADDR-1:0] i_addr0,
    input  logic [NB_DATA-1:0]          i_wdata0,
    output logic                        o_gnt0,
    output logic                        o_rvalid0,
    output logic [NB_DATA-1:0]          o_rdata0,
    input  logic                        i_req1,
    input  logic                        i_we1,
    input  logic [LOG2_N_DATA_ADDR-1:0] i_addr1,
    input  logic [NB_DATA-1:0]          i_wdata1,
    output logic                        o_gnt1,
    output logic                        o_rvalid1,
    output logic [NB_DATA-1:0]          o_rdata1,
    output logic [LOG2_N_DATA_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0]          o_mem_wdata,
    output logic                        o_mem_wr,
    output logic                        o_mem_rd,
    input  logic [NB_DATA-1:0]          i_mem_rdata,
    output logic                        o_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic                          last_gnt_q, last_gnt_d;
    logic                          owner_q, owner_d;
    logic [LOG2_N_DATA_ADDR-1:0]   addr_q, addr_d;
    logic [NB_DATA-1:0]            wdata_q, wdata_d;
    logic                          wr_q, wr_d;
    logic                          rd_q, rd_d;
    logic [1:0]                    gnt_q, gnt_d;
    logic                          win1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            gnt_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            gnt_q      <= gnt_d;
        end
    end

    // Port 1 wins alone, or on a tie when round-robin says it is its turn.
    always_comb begin
        win1 = 1'b0;
        if (i_req1) begin
            if (!i_req0)
                win1 = 1'b1;
            else if (FIXED_PRIO == 0)
                win1 = !last_gnt_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        gnt_d      = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    owner_d    = win1;
                    last_gnt_d = win1;
                    addr_d     = win1 ? i_addr1 : i_addr0;
                    wdata_d    = win1 ? i_wdata1 : i_wdata0;
                    wr_d       = win1 ? i_we1 : i_we0;
                    rd_d       = win1 ? !i_we1 : !i_we0;
                    gnt_d      = win1 ? 2'b10 : 2'b01;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wr_d    = 1'b0;
                rd_d    = 1'b0;
                gnt_d   = 2'b00;
                state_d = wr_q ? IDLE : RDATA;
            end
            RDATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_gnt0      = gnt_q[0];
    assign o_gnt1      = gnt_q[1];
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_wr    = wr_q;
    assign o_mem_rd    = rd_q;
    assign o_busy      = (state_q != IDLE);

    // Read data is a pass-through of the memory's own output register.
    assign o_rvalid0 = (state_q == RDATA) && !owner_q;
    assign o_rvalid1 = (state_q == RDATA) && owner_q;
    assign o_rdata0  = o_rvalid0 ? i_mem_rdata : '0;
    assign o_rdata1  = o_rvalid1 ? i_mem_rdata : '0;

endmodule
